ddr3_port_arbiter: RTL

Two-master arbiter that shares the single 32-bit CPU-side port of the DDR3 cache controller between two requesters, e.g. the CPU data bus (m0) and a DMA/VGA fetch engine (m1). It accepts level-held read/write requests, grants one master at a time, forwards that master's access to the cache controller, and returns the acknowledge and read data only to the granted master. Each transaction is a single 32-bit word.

---
 rtl/ddr3_port_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ddr3_port_arbiter.sv
// Two-master arbiter sharing the 32-bit CPU-side port of the DDR3 cache controller.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   m0_*, m1_*                : master ports
//                               addr/data/we/rd in, registered data/ack out
//   s_*                       : registered slave strobes/addr/data out, data/ack in
//   state_value               : debug {12'b0, last_grant, grant, state}
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin tie breaking.
// Without it, ties use fixed priority with m0 winning.
module ddr3_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_data_i,
   output logic [DATA_W-1:0] m0_data_o,
   input  logic              m0_we_i,
   input  logic              m0_rd_i,
   output logic              m0_ack_o,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_data_i,
   output logic [DATA_W-1:0] m1_data_o,
   input  logic              m1_we_i,
   input  logic              m1_rd_i,
   output logic              m1_ack_o,
   output logic [ADDR_W-1:0] s_addr_o,
   output logic [DATA_W-1:0] s_data_o,
   input  logic [DATA_W-1:0] s_data_i,
   output logic              s_we_o,
   output logic              s_rd_o,
   input  logic              s_ack_i,
   output logic [15:0]       state_value
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY0   = 2'd1,
      BUSY1   = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t            state, state_d;
   logic              grant, grant_d;
   logic              last_grant, last_grant_d;
   logic [ADDR_W-1:0] s_addr_d;
   logic [DATA_W-1:0] s_data_d;
   logic              s_we_d, s_rd_d;
   logic [DATA_W-1:0] m0_data_d, m1_data_d;
   logic              m0_ack_d, m1_ack_d;

   logic req0, req1;
   logic winner;
   logic gnt_req;

   assign req0 = m0_we_i | m0_rd_i;
   assign req1 = m1_we_i | m1_rd_i;

   // Winner selection in IDLE; only meaningful when some request is up.
   always_comb begin
      winner = 1'b0;
      if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
         winner = ~last_grant;
`else
         winner = 1'b0;
`endif
      end else if (req1) begin
         winner = 1'b1;
      end
   end

   // Request of the master currently holding the grant (used in RELEASE).
   assign gnt_req = grant ? req1 : req0;

   always_comb begin
      state_d      = state;
      grant_d      = grant;
      last_grant_d = last_grant;
      s_addr_d     = s_addr_o;
      s_data_d     = s_data_o;
      s_we_d       = s_we_o;
      s_rd_d       = s_rd_o;
      m0_data_d    = m0_data_o;
      m1_data_d    = m1_data_o;
      m0_ack_d     = 1'b0;
      m1_ack_d     = 1'b0;

      unique case (state)
         IDLE: begin
            if (req0 || req1) begin
               grant_d = winner;
               if (winner) begin
                  s_addr_d = m1_addr_i;
                  s_data_d = m1_data_i;
                  s_we_d   = m1_we_i;
                  // A simultaneous we+rd is treated as a write.
                  s_rd_d   = m1_rd_i & ~m1_we_i;
                  state_d  = BUSY1;
               end else begin
                  s_addr_d = m0_addr_i;
                  s_data_d = m0_data_i;
                  s_we_d   = m0_we_i;
                  s_rd_d   = m0_rd_i & ~m0_we_i;
                  state_d  = BUSY0;
               end
            end
         end
         BUSY0: begin
            if (s_ack_i) begin
               if (s_rd_o) m0_data_d = s_data_i;
               m0_ack_d     = 1'b1;
               s_we_d       = 1'b0;
               s_rd_d       = 1'b0;
               last_grant_d = 1'b0;
               state_d      = RELEASE;
            end
         end
         BUSY1: begin
            if (s_ack_i) begin
               if (s_rd_o) m1_data_d = s_data_i;
               m1_ack_d     = 1'b1;
               s_we_d       = 1'b0;
               s_rd_d       = 1'b0;
               last_grant_d = 1'b1;
               state_d      = RELEASE;
            end
         end
         RELEASE: begin
            // Wait for the served master to drop its level request so
            // it is not reissued as a second transaction.
            if (!gnt_req) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         s_addr_o   <= '0;
         s_data_o   <= '0;
         s_we_o     <= 1'b0;
         s_rd_o     <= 1'b0;
         m0_data_o  <= '0;
         m1_data_o  <= '0;
         m0_ack_o   <= 1'b0;
         m1_ack_o   <= 1'b0;
      end else begin
         state      <= state_d;
         grant      <= grant_d;
         last_grant <= last_grant_d;
         s_addr_o   <= s_addr_d;
         s_data_o   <= s_data_d;
         s_we_o     <= s_we_d;
         s_rd_o     <= s_rd_d;
         m0_data_o  <= m0_data_d;
         m1_data_o  <= m1_data_d;
         m0_ack_o   <= m0_ack_d;
         m1_ack_o   <= m1_ack_d;
      end
   end

   assign state_value = {12'b0, last_grant, grant, state};

endmodule
